fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch front end with a small in-order queue. Instructions are
//   fetched from a combinational instruction memory at fetch_pc. Each one is
//   captured together with its address into a DEPTH-entry circular buffer.
//   The head of that buffer is presented to decode.
//   A redirect flushes the queue and restarts fetch at a new target.
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous active-high reset
//   imem_addr       fetch address to instruction memory (fetch_pc)
//   imem_data       instruction at imem_addr, same cycle
//   out_valid       head entry valid (count != 0)
//   out_ready       decode consumes head when out_valid is high
//   out_instr       head instruction (registered)
//   out_pc          head instruction address (registered)
//   redirect_valid  flush queue and restart fetch at the target
//   redirect_rel    0: absolute target, 1: base + signed word offset
//   redirect_base   absolute target, or base PC for a relative redirect
//   redirect_off    signed word offset for relative redirects
//   count           queue occupancy
//   align_err       sticky: an absolute redirect target was not word aligned
module fetch_queue #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int OFF_W   = 26,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  input  logic                         redirect_valid,
  input  logic                         redirect_rel,
  input  logic [ADDR_W-1:0]            redirect_base,
  input  logic [OFF_W-1:0]             redirect_off,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         align_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   occ;

  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];

  logic               full;
  logic               do_pop;
  logic               do_push;
  logic               misaligned_abs;
  logic [ADDR_W-1:0]  off_ext;
  logic [ADDR_W-1:0]  target_abs;
  logic [ADDR_W-1:0]  target_rel;
  logic [ADDR_W-1:0]  target;

  // Offset is a signed word count; the size cast sign-extends it to the
  // address width before scaling to bytes. The sum wraps modulo 2^ADDR_W.
  assign off_ext    = ADDR_W'(signed'(redirect_off));
  assign target_rel = redirect_base + (off_ext << 2);
  assign target_abs = {redirect_base[ADDR_W-1:2], 2'b00};
  assign target     = redirect_rel ? target_rel : target_abs;

  assign misaligned_abs = !redirect_rel && (redirect_base[1:0] != 2'b00);

  assign full      = (occ == CNT_W'(DEPTH));
  assign out_valid = (occ != '0);
  assign do_pop    = out_valid && out_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign do_push   = !redirect_valid && (!full || do_pop);

  assign imem_addr = fetch_pc;
  assign out_instr = instr_q[head];
  assign out_pc    = pc_q[head];
  assign count     = occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      align_err <= 1'b0;
    end else if (redirect_valid) begin
      // Flush: discard every entry, including one decode may be taking now.
      fetch_pc <= target;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      if (misaligned_abs) begin
        align_err <= 1'b1;
      end
    end else begin
      if (do_push) begin
        tail     <= tail + PTR_W'(1);
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (do_pop) begin
        head <= head + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      instr_q[tail] <= imem_data;
      pc_q[tail]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: default parameters
  logic        a_reset, a_out_ready, a_redirect_valid, a_redirect_rel;
  logic [31:0] a_redirect_base;
  logic [25:0] a_redirect_off;
  logic [31:0] a_imem_addr, a_imem_data, a_out_instr, a_out_pc;
  logic        a_out_valid, a_align_err;
  logic [2:0]  a_count;

  // DUT b: reset PC near the top of the address space
  logic        b_reset, b_out_ready;
  logic [31:0] b_imem_addr, b_imem_data, b_out_instr, b_out_pc;
  logic        b_out_valid, b_align_err;
  logic [2:0]  b_count;

  assign a_imem_data = a_imem_addr ^ TAG;
  assign b_imem_data = b_imem_addr ^ TAG;

  fetch_queue dut_a (
    .clk(clk), .reset(a_reset),
    .imem_addr(a_imem_addr), .imem_data(a_imem_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_instr(a_out_instr), .out_pc(a_out_pc),
    .redirect_valid(a_redirect_valid), .redirect_rel(a_redirect_rel),
    .redirect_base(a_redirect_base), .redirect_off(a_redirect_off),
    .count(a_count), .align_err(a_align_err)
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .reset(b_reset),
    .imem_addr(b_imem_addr), .imem_data(b_imem_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_instr(b_out_instr), .out_pc(b_out_pc),
    .redirect_valid(1'b0), .redirect_rel(1'b0),
    .redirect_base(32'h0), .redirect_off(26'h0),
    .count(b_count), .align_err(b_align_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_a();
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
  endtask

  task automatic redirect_a(input logic rel, input logic [31:0] base, input logic [25:0] off);
    a_redirect_valid = 1'b1;
    a_redirect_rel   = rel;
    a_redirect_base  = base;
    a_redirect_off   = off;
    step();
    a_redirect_valid = 1'b0;
  endtask

  task automatic check_head_a(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, a_out_valid, 1'b1);
    check({tag, "_pc"},    a_out_pc, pc);
    check({tag, "_instr"}, a_out_instr, pc ^ TAG);
  endtask

  initial begin
    a_reset = 1'b1; a_out_ready = 1'b0; a_redirect_valid = 1'b0;
    a_redirect_rel = 1'b0; a_redirect_base = '0; a_redirect_off = '0;
    b_reset = 1'b1; b_out_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_count", a_count, 3'd0);
    check("rst_addr",  a_imem_addr, 32'h0);
    check("rst_align", a_align_err, 1'b0);

    // Streaming: one instruction per cycle, occupancy steady at 1
    a_reset = 1'b0; a_out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_head_a("stream", 32'(4 * (k - 1)));
      check("stream_count", a_count, 3'd1);
    end
    check("stream_addr", a_imem_addr, 32'h18);

    // Backpressure: fill to 4, fetch address holds at 0x10
    do_reset_a();
    a_out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("bp_count", a_count, (k < 4) ? 3'(k) : 3'd4);
    end
    check("bp_addr", a_imem_addr, 32'h10);
    check_head_a("bp_head", 32'h0);
    // Release: pop and push together on a full queue, no loss or duplication
    a_out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_head_a("bp_rel", 32'(4 * k));
      check("bp_rel_count", a_count, 3'd4);
    end

    // Relative redirect with count=3: base 0x100, off -2 words
    do_reset_a();
    a_out_ready = 1'b0;
    step(); step(); step();
    check("rel_pre_count", a_count, 3'd3);
    redirect_a(1'b1, 32'h100, 26'h3FF_FFFE);
    check("rel_valid", a_out_valid, 1'b0);
    check("rel_count", a_count, 3'd0);
    check("rel_addr",  a_imem_addr, 32'hF8);
    a_out_ready = 1'b1;
    step();
    check_head_a("rel_head", 32'hF8);
    check("rel_align", a_align_err, 1'b0);

    // Relative redirect from a misaligned base keeps the low bits, no error
    redirect_a(1'b1, 32'h102, 26'h1);
    check("relmis_addr",  a_imem_addr, 32'h106);
    check("relmis_align", a_align_err, 1'b0);

    // Relative redirect wrapping below zero
    redirect_a(1'b1, 32'h0, 26'h3FF_FFFF);
    check("relwrap_addr", a_imem_addr, 32'hFFFF_FFFC);

    // Absolute misaligned redirect: target rounded down, sticky error
    redirect_a(1'b0, 32'h203, 26'h0);
    check("abs_addr",  a_imem_addr, 32'h200);
    check("abs_align", a_align_err, 1'b1);
    check("abs_count", a_count, 3'd0);
    step();
    check_head_a("abs_head", 32'h200);
    redirect_a(1'b0, 32'h300, 26'h0);
    step(); step();
    check("abs_sticky", a_align_err, 1'b1);
    check_head_a("abs2_head", 32'h304);
    do_reset_a();
    check("abs_clr", a_align_err, 1'b0);

    // Redirect with concurrent pop on a full queue
    a_out_ready = 1'b0;
    step(); step(); step(); step();
    check("full_count", a_count, 3'd4);
    a_out_ready = 1'b1;
    redirect_a(1'b0, 32'h40, 26'h0);
    check("rdpop_count", a_count, 3'd0);
    check("rdpop_valid", a_out_valid, 1'b0);
    check("rdpop_addr",  a_imem_addr, 32'h40);
    step();
    check_head_a("rdpop_h0", 32'h40);
    step();
    check_head_a("rdpop_h1", 32'h44);

    // Back-to-back redirects: the last one wins
    redirect_a(1'b0, 32'h80, 26'h0);
    redirect_a(1'b0, 32'h90, 26'h0);
    check("b2b_addr",  a_imem_addr, 32'h90);
    check("b2b_count", a_count, 3'd0);
    step();
    check_head_a("b2b_head", 32'h90);

    // Reset overrides a simultaneous misaligned redirect
    a_redirect_valid = 1'b1; a_redirect_rel = 1'b0; a_redirect_base = 32'h203;
    a_reset = 1'b1;
    step();
    a_reset = 1'b0; a_redirect_valid = 1'b0;
    check("rstov_addr",  a_imem_addr, 32'h0);
    check("rstov_align", a_align_err, 1'b0);
    check("rstov_valid", a_out_valid, 1'b0);

    // Wrap of fetch_pc past 2^32, then reset mid-stream
    step();
    b_reset = 1'b0; b_out_ready = 1'b1;
    step();
    check("wrap_h0", b_out_pc, 32'hFFFF_FFF8);
    check("wrap_i0", b_out_instr, 32'hFFFF_FFF8 ^ TAG);
    step();
    check("wrap_h1", b_out_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_h2", b_out_pc, 32'h0);
    step();
    check("wrap_h3", b_out_pc, 32'h4);
    check("wrap_count", b_count, 3'd1);
    check("wrap_valid", b_out_valid, 1'b1);
    b_reset = 1'b1;
    step();
    check("wrap_rst_valid", b_out_valid, 1'b0);
    check("wrap_rst_addr",  b_imem_addr, 32'hFFFF_FFF8);
    check("wrap_rst_align", b_align_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
